// File: rtl/minmax_reduce_int.sv
// minmax_reduce_int
// Streaming signed min/max reduction. Elements arrive one per cycle over a
// valid/ready interface until in_last. The block then presents the packet's
// extreme value, the index of its first occurrence and the element count,
// and holds them until the downstream takes the result.
//
// Element count and index saturate at 2^IDX_W-1. A sticky overflow flag marks
// packets longer than that. Elements past saturation are still compared, and a
// late replacement records the saturated index.

module minmax_reduce_int #(
    parameter int WIDTH     = 64,
    parameter int IDX_W     = 16,
    parameter int IMPL_TYPE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] CNT_MAX = '1;
    localparam logic [IDX_W-1:0] CNT_ONE = IDX_W'(1);

    state_t           r_state;
    logic [WIDTH-1:0] r_best;
    logic [IDX_W-1:0] r_best_idx;
    logic [IDX_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_mode;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_cnt_sat;
    logic [WIDTH-1:0] w_cmp_a;
    logic [WIDTH-1:0] w_cmp_b;
    logic             w_replace;

    assign w_accept  = in_valid & r_in_ready;
    assign w_cnt_sat = (r_cnt == CNT_MAX);

    // The comparator always answers "a > b". In min mode the question is
    // "best > new", and in max mode it is "new > best". Equality never
    // replaces, so the first occurrence wins ties.
    assign w_cmp_a = r_mode ? in_data : r_best;
    assign w_cmp_b = r_mode ? r_best  : in_data;

    // Full-width signed greater-than. The variants are functionally identical.
    // They let the reduction be benchmarked against different comparator
    // structures.
    generate
        if (IMPL_TYPE == 1) begin : g_cmp_offset
            // Flipping the sign bit maps two's complement onto offset binary.
            // An unsigned compare then orders the values correctly.
            logic [WIDTH-1:0] w_a_ofs;
            logic [WIDTH-1:0] w_b_ofs;
            assign w_a_ofs   = {~w_cmp_a[WIDTH-1], w_cmp_a[WIDTH-2:0]};
            assign w_b_ofs   = {~w_cmp_b[WIDTH-1], w_cmp_b[WIDTH-2:0]};
            assign w_replace = (w_a_ofs > w_b_ofs);
        end else if (IMPL_TYPE == 2) begin : g_cmp_sub
            // b - a is evaluated one bit wider so it cannot overflow. It is
            // negative exactly when a > b.
            logic [WIDTH:0] w_diff;
            assign w_diff    = {w_cmp_b[WIDTH-1], w_cmp_b} - {w_cmp_a[WIDTH-1], w_cmp_a};
            assign w_replace = w_diff[WIDTH];
        end else begin : g_cmp_native
            assign w_replace = ($signed(w_cmp_a) > $signed(w_cmp_b));
        end
    endgenerate

    // Packet FSM: load on the first beat, fold later beats into the running
    // extreme, then hold the result until it is taken.
    // NOTE: every register here is assigned with <= so all of them update
    // together from pre-edge values. Using = would make later statements see
    // half-updated state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset too, not just the state
            // bits. The result bus then reads as zero after reset instead of
            // showing a stale or unknown value.
            r_state     <= S_IDLE;
            r_best      <= '0;
            r_best_idx  <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_mode      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_best     <= in_data;
                        r_best_idx <= '0;
                        r_cnt      <= CNT_ONE;
                        r_ovf      <= 1'b0;
                        r_mode     <= mode;
                        if (in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end

                S_ACCUM: begin
                    if (w_accept) begin
                        // r_cnt is the index of the current element. Once it
                        // saturates, it is also the index a late winner records.
                        if (w_replace) begin
                            r_best     <= in_data;
                            r_best_idx <= r_cnt;
                        end
                        if (w_cnt_sat) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_ONE;
                        end
                        if (in_last) begin
                            r_state     <= S_DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_best;
    assign out_idx   = r_best_idx;
    assign out_count = r_cnt;
    assign out_ovf   = r_ovf;

endmodule
